// File: rtl/relu_backward.sv
// relu_backward: streaming ReLU gradient gate.
// A tile of DEPTH forward ReLU inputs is reduced to a 1-bit positivity mask.
// The matching DEPTH gradients are then passed through where the mask bit is
// set and replaced by +0.0 where it is clear. Gradient bits are never modified.
module relu_backward #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fwd_valid,
    output logic        fwd_ready,
    input  logic [31:0] fwd_data,
    input  logic        grad_valid,
    output logic        grad_ready,
    input  logic [31:0] grad_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CAPTURE = 1'b0,
        APPLY   = 1'b1
    } state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DEPTH-1:0]  mask_reg;
    logic              done_reg;
    logic              out_valid_reg;
    logic [31:0]       out_data_reg;
    logic              out_last_reg;

    logic              fwd_fire;
    logic              grad_fire;
    logic              idx_at_last;
    logic              fwd_positive;
    logic [31:0]       grad_gated;

    // Only one input channel is open at a time. The gradient side is further
    // throttled by the output register, which accepts a new element when it is
    // empty or is draining in this same cycle.
    assign fwd_ready  = (state_reg == CAPTURE);
    assign grad_ready = (state_reg == APPLY) && (!out_valid_reg || out_ready);

    assign fwd_fire    = fwd_valid && fwd_ready;
    assign grad_fire   = grad_valid && grad_ready;
    assign idx_at_last = (idx_reg == IDX_LAST);

    // Strictly positive: sign clear and not +0.0. A positive NaN counts as positive.
    assign fwd_positive = !fwd_data[31] && (|fwd_data[30:0]);

    // Pure bit gating, no arithmetic; a blocked gradient becomes +0.0.
    assign grad_gated = mask_reg[idx_reg] ? grad_data : 32'h0000_0000;

    // Phase sequencing: index walks the tile once per phase, done pulses after the last gradient
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CAPTURE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                CAPTURE: begin
                    if (fwd_fire) begin
                        if (idx_at_last) begin
                            idx_reg   <= '0;
                            state_reg <= APPLY;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                APPLY: begin
                    if (grad_fire) begin
                        if (idx_at_last) begin
                            idx_reg   <= '0;
                            state_reg <= CAPTURE;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= CAPTURE;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            // Each mask bit records the positivity of the forward element at its index
            always_ff @(posedge clk) begin
                if (reset) begin
                    mask_reg[gi] <= 1'b0;
                end else if (fwd_fire && (idx_reg == IDX_W'(gi))) begin
                    mask_reg[gi] <= fwd_positive;
                end
            end
        end
    endgenerate

    // Output register: loads on every gradient handshake, otherwise drains on an out handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 32'h0000_0000;
            out_last_reg  <= 1'b0;
        end else if (grad_fire) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= grad_gated;
            out_last_reg  <= idx_at_last;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_relu_backward.sv
// Directed bench for relu_backward: a DEPTH=4 instance for gating, backpressure,
// phase exclusion, reset and back-to-back tiles, and a DEPTH=64 instance for
// full-throughput streaming.
`timescale 1ns/1ps
module tb_relu_backward;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        a_fwd_valid, a_fwd_ready, a_grad_valid, a_grad_ready;
    logic        a_out_valid, a_out_ready, a_out_last, a_done;
    logic [31:0] a_fwd_data, a_grad_data, a_out_data;

    relu_backward #(.DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .fwd_valid(a_fwd_valid), .fwd_ready(a_fwd_ready), .fwd_data(a_fwd_data),
        .grad_valid(a_grad_valid), .grad_ready(a_grad_ready), .grad_data(a_grad_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .done(a_done)
    );

    // DEPTH=64 instance
    logic        b_fwd_valid, b_fwd_ready, b_grad_valid, b_grad_ready;
    logic        b_out_valid, b_out_ready, b_out_last, b_done;
    logic [31:0] b_fwd_data, b_grad_data, b_out_data;

    relu_backward #(.DEPTH(64)) u_dut64 (
        .clk(clk), .reset(reset),
        .fwd_valid(b_fwd_valid), .fwd_ready(b_fwd_ready), .fwd_data(b_fwd_data),
        .grad_valid(b_grad_valid), .grad_ready(b_grad_ready), .grad_data(b_grad_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .done(b_done)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] fwd_vec  [4];
    logic [31:0] grad_vec [4];
    logic [31:0] exp_vec  [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    // Exact float32 encoding of a small positive integer.
    function automatic logic [31:0] f32_of(input int n);
        int e;
        e = 0;
        for (int k = 0; k < 31; k++) if (n >= (1 << k)) e = k;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    // Feed fwd_vec into the DEPTH=4 unit, one element per cycle.
    task automatic capture4(input bit noise_grad, input bit hold_check, input logic [31:0] held);
        for (int i = 0; i < 4; i++) begin
            a_fwd_valid  = 1'b1;
            a_fwd_data   = fwd_vec[i];
            a_grad_valid = noise_grad;
            a_grad_data  = 32'h4120_0000;
            @(negedge clk);
            check("cap_fwd_ready", 32'(a_fwd_ready), 32'd1);
            if (noise_grad) check("cap_grad_ready", 32'(a_grad_ready), 32'd0);
            if (hold_check) begin
                check("held_valid", 32'(a_out_valid), 32'd1);
                check("held_data", a_out_data, held);
                check("held_last", 32'(a_out_last), 32'd1);
            end else begin
                check("cap_out_valid", 32'(a_out_valid), 32'd0);
            end
            $display("cap elem=%0d fwd=%h", i, fwd_vec[i]);
            @(posedge clk); #1;
        end
        a_fwd_valid  = 1'b0;
        a_grad_valid = 1'b0;
    endtask

    // Stream grad_vec and collect outputs against exp_vec.
    task automatic apply4(input bit bp, input bit noise_fwd, input bit hold_last);
        int gi, oi, done_cnt, cyc;
        bit stalled, fin;
        logic [31:0] prev;
        gi = 0; oi = 0; done_cnt = 0; cyc = 0;
        stalled = 1'b0; fin = 1'b0; prev = '0;
        while (!fin && cyc < 60) begin
            a_grad_valid = (gi < 4);
            a_grad_data  = grad_vec[(gi < 4) ? gi : 3];
            a_fwd_valid  = noise_fwd && (gi < 4);
            a_fwd_data   = 32'h3F80_0000;
            if (hold_last && oi == 3) a_out_ready = 1'b0;
            else if (bp)              a_out_ready = (cyc % 2 == 0);
            else                      a_out_ready = 1'b1;
            @(negedge clk);
            if (gi < 4) check("grad_ready_rule", 32'(a_grad_ready), 32'(!a_out_valid || a_out_ready));
            if (noise_fwd && gi < 4) check("apply_fwd_ready", 32'(a_fwd_ready), 32'd0);
            if (stalled) begin
                check("stall_valid", 32'(a_out_valid), 32'd1);
                check("stall_data", a_out_data, prev);
            end
            if (a_done) begin
                done_cnt++;
                check("done_with_last", 32'(a_out_valid && a_out_last), 32'd1);
            end
            if (a_out_valid && a_out_ready) begin
                check("out_data", a_out_data, exp_vec[oi]);
                check("out_last", 32'(a_out_last), 32'(oi == 3));
                $display("out elem=%0d data=%h last=%0b", oi, a_out_data, a_out_last);
                oi++;
            end
            stalled = a_out_valid && !a_out_ready;
            prev    = a_out_data;
            if (a_grad_valid && a_grad_ready) gi++;
            if (oi == 4) fin = 1'b1;
            if (hold_last && oi == 3 && gi == 4 && a_out_valid && a_out_last) fin = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        a_grad_valid = 1'b0;
        a_fwd_valid  = 1'b0;
        check("apply_complete", 32'(fin), 32'd1);
        check("done_count", done_cnt, 32'd1);
    endtask

    task automatic drain_held(input logic [31:0] held);
        a_out_ready = 1'b1;
        @(negedge clk);
        check("drain_valid", 32'(a_out_valid), 32'd1);
        check("drain_data", a_out_data, held);
        check("drain_last", 32'(a_out_last), 32'd1);
        $display("drain held data=%h", a_out_data);
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        @(negedge clk);
        check("drain_empty", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        a_fwd_valid = 0; a_grad_valid = 0; a_out_ready = 0; a_fwd_data = '0; a_grad_data = '0;
        b_fwd_valid = 0; b_grad_valid = 0; b_out_ready = 0; b_fwd_data = '0; b_grad_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", a_out_data, 32'd0);
        check("rst_out_last", 32'(a_out_last), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_fwd_ready", 32'(a_fwd_ready), 32'd1);
        check("rst_grad_ready", 32'(a_grad_ready), 32'd0);
        check("rst64_fwd_ready", 32'(b_fwd_ready), 32'd1);
        check("rst64_grad_ready", 32'(b_grad_ready), 32'd0);
        check("rst64_out_valid", 32'(b_out_valid), 32'd0);
        $display("reset state checked");
        @(posedge clk); #1;

        // Basic gating: +1, -1, +0, -0
        fwd_vec  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000};
        grad_vec = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        exp_vec  = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        capture4(0, 0, '0);
        apply4(0, 0, 0);

        // Backpressure with special values: +NaN and +denormal pass, -Inf blocks
        fwd_vec  = '{32'h4000_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001};
        grad_vec = '{32'h8000_0000, 32'h7F80_0000, 32'h3F80_0000, 32'hFFC0_0000};
        exp_vec  = '{32'h8000_0000, 32'h7F80_0000, 32'h0000_0000, 32'hFFC0_0000};
        capture4(0, 0, '0);
        apply4(1, 0, 0);

        // Phase exclusion: stray grad during capture, stray positive fwd during apply
        fwd_vec  = '{32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hC000_0000};
        grad_vec = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        exp_vec  = '{32'h0000_0000, 32'h2222_2222, 32'h3333_3333, 32'h0000_0000};
        capture4(1, 0, '0);
        apply4(0, 1, 0);

        // Reset after two of four gradients, with an output pending
        fwd_vec  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        capture4(0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            a_grad_valid = 1'b1;
            a_grad_data  = 32'h4000_0000 + i;
            a_out_ready  = 1'b1;
            @(negedge clk);
            check("pre_rst_grad_ready", 32'(a_grad_ready), 32'd1);
            $display("pre-reset grad elem=%0d", i);
            @(posedge clk); #1;
        end
        a_grad_valid = 1'b0;
        a_out_ready  = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("pre_rst_out_valid", 32'(a_out_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_fwd_ready", 32'(a_fwd_ready), 32'd1);
        check("mid_rst_grad_ready", 32'(a_grad_ready), 32'd0);
        check("mid_rst_done", 32'(a_done), 32'd0);
        $display("mid-operation reset checked");
        @(posedge clk); #1;
        fwd_vec  = '{32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000};
        grad_vec = '{32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000};
        exp_vec  = '{32'h0000_0000, 32'h4110_0000, 32'h0000_0000, 32'h4130_0000};
        capture4(0, 0, '0);
        apply4(0, 0, 0);

        // Back-to-back tiles: last output held while the next tile captures
        fwd_vec  = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000};
        grad_vec = '{32'h40E0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000};
        exp_vec  = '{32'h40E0_0000, 32'h4100_0000, 32'h0000_0000, 32'h4120_0000};
        capture4(0, 0, '0);
        apply4(0, 0, 1);
        fwd_vec  = '{32'h8000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000};
        capture4(0, 1, 32'h4120_0000);
        drain_held(32'h4120_0000);
        grad_vec = '{32'h4130_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000};
        exp_vec  = '{32'h0000_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000};
        apply4(0, 0, 0);

        // Full throughput on the DEPTH=64 unit
        for (int i = 0; i < 64; i++) begin
            b_fwd_valid = 1'b1;
            b_fwd_data  = f32_of(i + 1);
            @(negedge clk);
            if (i == 0 || i == 63) check("t64_fwd_ready", 32'(b_fwd_ready), 32'd1);
            @(posedge clk); #1;
        end
        b_fwd_valid = 1'b0;
        b_out_ready = 1'b1;
        $display("t64 capture complete");
        for (int c = 0; c < 68; c++) begin
            b_grad_valid = (c < 64);
            b_grad_data  = f32_of(c + 1);
            @(negedge clk);
            if (c < 64) check("t64_grad_ready", 32'(b_grad_ready), 32'd1);
            if (c == 0) check("t64_fwd_blocked", 32'(b_fwd_ready), 32'd0);
            if (c == 64) check("t64_fwd_reopen", 32'(b_fwd_ready), 32'd1);
            check("t64_out_valid", 32'(b_out_valid), 32'(c >= 1 && c <= 64));
            check("t64_done", 32'(b_done), 32'(c == 64));
            if (b_out_valid) begin
                check("t64_out_data", b_out_data, f32_of(c));
                check("t64_out_last", 32'(b_out_last), 32'(c == 64));
                $display("t64 cycle=%0d data=%h last=%0b", c, b_out_data, b_out_last);
            end
            @(posedge clk); #1;
        end
        b_grad_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relu_backward.md
# relu_backward

Streaming ReLU gradient unit for the training path of the CNN accelerator. It captures a tile of DEPTH forward-pass ReLU inputs (IEEE-754 single precision) as a 1-bit positivity mask. It then gates the matching stream of DEPTH incoming gradients: each gradient is passed where its forward input was strictly positive and replaced by +0.0 elsewhere. It sits between the loss/upstream gradient source and the convolution weight-update logic, as the backward counterpart of the forward ReLU stage.

## Interface
- DEPTH, 64: elements per tile; power of two, 2..1024.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- fwd_valid  in  1  forward element present.
- fwd_ready  out  1  unit accepts forward element.
- fwd_data  in  32  forward ReLU input (float32).
- grad_valid  in  1  gradient element present.
- grad_ready  out  1  unit accepts gradient element.
- grad_data  in  32  upstream gradient (float32).
- out_valid  out  1  gated gradient present.
- out_ready  in  1  downstream accepts output.
- out_data  out  32  gated gradient.
- out_last  out  1  marks element DEPTH-1 of the tile on out_data.
- done  out  1  one-cycle pulse when the last gradient of a tile is accepted.

## Operation
- Handshake on any channel completes in a cycle where valid && ready are both high. Each handshake transfers exactly one element.
- Mask rule: mask = 1 iff fwd_data[31] == 0 and fwd_data[30:0] != 0. Under this rule, +0.0 gives mask 0, and -0.0 and all negatives give mask 0. NaN with sign 0 gives mask 1.
- Storage: DEPTH-bit mask register, plus an index counter of width log2(DEPTH).
- FSM, two states:
  - CAPTURE:
    - fwd_ready = 1, grad_ready = 0.
    - Each fwd handshake writes mask[idx] and increments idx.
    - A handshake at idx == DEPTH-1 wraps idx to 0 and moves the FSM to APPLY.
  - APPLY:
    - fwd_ready = 0, grad_ready = !out_valid || out_ready.
    - Each grad handshake loads the output register and increments idx. out_data = mask[idx] ? grad_data : 32'h0000_0000. out_last = (idx == DEPTH-1).
    - The handshake at idx == DEPTH-1 wraps idx to 0, moves the FSM to CAPTURE, and sets done for the next cycle.
- Gradient bits pass unmodified when mask = 1 (including -0.0, NaN, Inf). There is no arithmetic.
- Output register drains independently. A new tile's CAPTURE may proceed while the last output of the previous tile is still held.
- Output register:
  - out_valid clears on an out handshake, unless a new grad handshake occurs in the same cycle.
  - In that case out_valid stays 1 with the new data, which gives full throughput.
- Inputs are ignored while their ready is low. Data on a channel with valid low is don't-care.

## Timing
- Reset values: FSM = CAPTURE, idx = 0, mask = all 0, out_valid = 0, out_data = 0, out_last = 0, done = 0. After reset, fwd_ready = 1 and grad_ready = 0.
- Reset mid-tile discards the partial mask and any pending output. No done pulse is produced.
- Forward capture: 1 element/cycle; DEPTH cycles minimum per tile.
- Gradient latency: out_valid is asserted the cycle after the grad handshake. Sustained throughput is 1 element/cycle with out_ready held high.
- Backpressure: out_ready low with out_valid high drops grad_ready in the same cycle (combinational). out_data and out_last hold stable until accepted.
- done is registered: high exactly one cycle, in the same cycle that out_valid first presents the out_last element.
- The CAPTURE→APPLY transition takes effect the cycle after the last fwd handshake. grad_ready can first be high in that cycle, so there is no bubble.
- The APPLY→CAPTURE transition likewise takes effect the next cycle: fwd_ready = 1 the cycle after the last grad handshake.

## Test plan
- Basic gating, DEPTH=4:
  - Stimulus: fwd = {3F800000 (1.0), BF800000 (-1.0), 00000000 (+0), 80000000 (-0)}; grad = {40000000, 40400000, 40800000, 40A00000}.
  - Required: out = {40000000, 0, 0, 0}, out_last only on the 4th output, one done pulse.
- Full throughput:
  - Stimulus: DEPTH=64, all fwd positive, grad = 1..64 as floats, out_ready held 1.
  - Required: 64 outputs on consecutive cycles, starting 1 cycle after the first grad handshake, values unchanged.
- Backpressure:
  - Stimulus: toggle out_ready 1/0 every cycle during APPLY.
  - Required: grad_ready follows !out_valid || out_ready; no lost or duplicated element; out_data is stable while stalled.
- Phase exclusion:
  - Stimulus: assert grad_valid during CAPTURE and fwd_valid during APPLY.
  - Required: respective ready stays 0, and mask/outputs are unaffected.
- Reset mid-operation:
  - Stimulus: assert reset after 2 of 4 grads are accepted, with out_valid = 1.
  - Required: next cycle out_valid = 0, fwd_ready = 1, no done pulse. A following complete tile gates correctly against a freshly captured mask.
- Back-to-back tiles:
  - Stimulus: hold out_ready = 0 on the last output while the next tile's fwd stream starts.
  - Required: the next tile's capture proceeds, the held output stays valid, and the second tile's results are correct.
